// File: rtl/parity_stream.sv
// parity_stream: accumulates parity over a frame of DATA_BITS-wide beats
// on a valid/ready input stream and returns one registered result per
// frame on a valid/ready output stream. Supports even/odd/mark/space modes
// in generate or check mode, with forced frame termination at BEATS_MAX beats.
// Optional feature macro: PARITY_ERR_CNT_EN adds the saturating err_count port.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. A valid source holds its payload stable until that edge.
// out_valid and all result fields stay stable until they are consumed.
module parity_stream #(
  parameter int DATA_BITS = 8,
  parameter int BEATS_MAX = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 check,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_last,
  input  logic                 in_parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_parity,
  output logic                 out_error,
  output logic                 out_overrun,
`ifdef PARITY_ERR_CNT_EN
  output logic [CNT_W-1:0]     err_count,
`endif
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(BEATS_MAX + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(BEATS_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state, state_d;
  logic            acc, acc_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic            check_q, check_d;
  logic            valid_d, parity_d, error_d, overrun_d;

  logic            accept;
  logic            first;
  logic            base_acc, sum_acc;
  logic [CW-1:0]   base_cnt, sum_cnt;
  logic [1:0]      beat_mode;
  logic            beat_check;
  logic            frame_end;
  logic            result;

  // A beat can enter whenever the result slot is empty or being drained.
  assign in_ready  = ~reset & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign dbg_state = state;

  // Next-state, accumulator and result computation.
  always_comb begin
    state_d    = state;
    acc_d      = acc;
    cnt_d      = cnt;
    mode_d     = mode_q;
    check_d    = check_q;
    valid_d    = out_valid;
    parity_d   = out_parity;
    error_d    = out_error;
    overrun_d  = out_overrun;

    // Any beat accepted outside ACCUM opens a new frame (IDLE, or HOLD
    // while the previous result is being consumed this same cycle).
    first      = (state != ACCUM);
    base_acc   = first ? 1'b0 : acc;
    base_cnt   = first ? '0 : cnt;
    beat_mode  = first ? mode : mode_q;
    beat_check = first ? check : check_q;
    sum_acc    = base_acc ^ (^in_data);
    sum_cnt    = base_cnt + CW'(1);
    frame_end  = in_last | (sum_cnt == MAX_CNT);

    case (beat_mode)
      2'b00:   result = sum_acc;
      2'b01:   result = ~sum_acc;
      2'b10:   result = 1'b1;
      default: result = 1'b0;
    endcase

    // Result consumed: slot empties unless refilled below.
    if (out_valid && out_ready) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end

    if (accept) begin
      mode_d  = beat_mode;
      check_d = beat_check;
      if (frame_end) begin
        state_d   = HOLD;
        valid_d   = 1'b1;
        parity_d  = result;
        overrun_d = ~in_last;
        // Overrun frames never saw their real last beat, so no check.
        error_d   = beat_check & in_last & (in_parity != result);
        acc_d     = 1'b0;
        cnt_d     = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum_acc;
        cnt_d   = sum_cnt;
      end
    end
  end

  // State and result registers; reset discards any frame or pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= 1'b0;
      cnt         <= '0;
      mode_q      <= 2'b00;
      check_q     <= 1'b0;
      out_valid   <= 1'b0;
      out_parity  <= 1'b0;
      out_error   <= 1'b0;
      out_overrun <= 1'b0;
    end else begin
      state       <= state_d;
      acc         <= acc_d;
      cnt         <= cnt_d;
      mode_q      <= mode_d;
      check_q     <= check_d;
      out_valid   <= valid_d;
      out_parity  <= parity_d;
      out_error   <= error_d;
      out_overrun <= overrun_d;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Count consumed results flagged as error or overrun, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (out_valid && out_ready && (out_error || out_overrun)
                 && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_parity_stream.sv
// tb_parity_stream: directed bench for parity_stream with BEATS_MAX=4.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_parity_stream;

  localparam int DATA_BITS = 8;
  localparam int BEATS_MAX = 4;
  localparam int CNT_W     = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]           mode;
  logic                 check;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_last;
  logic                 in_parity;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_parity;
  logic                 out_error;
  logic                 out_overrun;
`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0]     err_count;
`endif
  logic [1:0]           dbg_state;

  parity_stream #(
    .DATA_BITS(DATA_BITS),
    .BEATS_MAX(BEATS_MAX),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .check(check),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .in_parity(in_parity),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_parity(out_parity),
    .out_error(out_error),
    .out_overrun(out_overrun),
`ifdef PARITY_ERR_CNT_EN
    .err_count(err_count),
`endif
    .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic last, input logic [1:0] m,
                       input logic c, input logic p);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    mode      = m;
    check     = c;
    in_parity = p;
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_parity = 1'b0;
  endtask

  // drive one beat for exactly one edge, then release the bus
  task automatic send(input logic [7:0] d, input logic last, input logic [1:0] m,
                      input logic c, input logic p);
    drive(d, last, m, c, p);
    tick();
    idle_in();
  endtask

  task automatic chk_result(input string tag, input logic v, input logic par,
                            input logic err, input logic ovr);
    chk({tag, ".valid"},   out_valid,   v);
    chk({tag, ".parity"},  out_parity,  par);
    chk({tag, ".error"},   out_error,   err);
    chk({tag, ".overrun"}, out_overrun, ovr);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset     = 1'b1;
    mode      = 2'b00;
    check     = 1'b0;
    out_ready = 1'b1;
    idle_in();
    tick();
    tick();

    // reset state
    chk_result("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.in_ready", in_ready, 1'b0);
    chk("reset.state", dbg_state, 2'd0);
`ifdef PARITY_ERR_CNT_EN
    chk("reset.err_count", err_count, 0);
`endif
    reset = 1'b0;
    #1;
    chk("post_reset.in_ready", in_ready, 1'b1);

    // generate even, single beat A5 (four ones) -> 0
    send(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0);
    chk_result("gen_even", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("gen_even.drained", out_valid, 1'b0);

    // generate odd, 01 03 07 -> six ones -> 1
    chk("gen_odd.ready0", in_ready, 1'b1);
    send(8'h01, 1'b0, 2'b01, 1'b0, 1'b0);
    chk("gen_odd.ready1", in_ready, 1'b1);
    chk("gen_odd.state_accum", dbg_state, 2'd1);
    send(8'h03, 1'b0, 2'b01, 1'b0, 1'b0);
    chk("gen_odd.ready2", in_ready, 1'b1);
    send(8'h07, 1'b1, 2'b01, 1'b0, 1'b0);
    chk_result("gen_odd", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("gen_odd.state_hold", dbg_state, 2'd2);
    tick();
    chk("gen_odd.drained", out_valid, 1'b0);

    // check even, FF 01 (nine ones) -> 1, in_parity 0 -> error
    send(8'hFF, 1'b0, 2'b00, 1'b1, 1'b0);
    send(8'h01, 1'b1, 2'b00, 1'b1, 1'b0);
    chk_result("chk_even", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
`ifdef PARITY_ERR_CNT_EN
    chk("chk_even.err_count", err_count, 1);
`endif

    // overrun at 4 beats: 01 00 00 00 -> parity 1, overrun, no error
    send(8'h01, 1'b0, 2'b00, 1'b1, 1'b1);
    send(8'h00, 1'b0, 2'b00, 1'b1, 1'b1);
    send(8'h00, 1'b0, 2'b00, 1'b1, 1'b1);
    send(8'h00, 1'b0, 2'b00, 1'b1, 1'b1);
    chk_result("overrun", 1'b1, 1'b1, 1'b0, 1'b1);
    // beat 5 opens a new frame in odd mode while the result drains
    chk("overrun.ready_same_cycle", in_ready, 1'b1);
    send(8'h03, 1'b0, 2'b01, 1'b0, 1'b0);
    chk("beat5.valid", out_valid, 1'b0);
    chk("beat5.state", dbg_state, 2'd1);
`ifdef PARITY_ERR_CNT_EN
    chk("overrun.err_count", err_count, 2);
`endif
    // mid-frame mode change ignored: acc=0, odd -> 1
    send(8'h00, 1'b1, 2'b00, 1'b0, 1'b0);
    chk_result("beat5_frame", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // backpressure: result of 0F even -> 0 held for three cycles
    out_ready = 1'b0;
    send(8'h0F, 1'b1, 2'b00, 1'b0, 1'b0);
    chk_result("bp.first", 1'b1, 1'b0, 1'b0, 1'b0);
    drive(8'h01, 1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp.in_ready_low", in_ready, 1'b0);
      tick();
      chk_result("bp.held", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    // release together with a new single-beat frame (01 even -> 1)
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_high", in_ready, 1'b1);
    tick();
    idle_in();
    chk_result("bp.next", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp.drained", out_valid, 1'b0);

    // reset during beat 2 of a 3-beat frame
    send(8'h01, 1'b0, 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    drive(8'h01, 1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    chk("rst.in_ready", in_ready, 1'b0);
    tick();
    reset = 1'b0;
    idle_in();
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.state", dbg_state, 2'd0);
    tick();
    chk("rst.no_result", out_valid, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    chk("rst.err_count", err_count, 0);
`endif

    // space mode, check with in_parity 0 -> parity 0, no error
    send(8'hFF, 1'b1, 2'b11, 1'b1, 1'b0);
    chk_result("space", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // mark mode, check with in_parity 0 -> parity 1, error
    send(8'h00, 1'b1, 2'b10, 1'b1, 1'b0);
    chk_result("mark", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("mark.drained", out_valid, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    chk("mark.err_count", err_count, 1);
`endif

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
